// File: rtl/bus_mem_slave.sv
// bus_mem_slave: synchronous memory slave for the instruction/data bus.
// Word-indexed storage with per-byte write lanes, configurable wait states
// (bus_wait stall), a one-cycle read-valid strobe and a one-cycle error strobe
// for out-of-range or conflicting (read+write) accesses.
// Optional build macro BUS_MEM_STATS_EN adds saturating access counters
// stat_reads / stat_writes / stat_errors.

module bus_mem_slave #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   bus_address,
    input  logic [DATA_WIDTH-1:0]   bus_write_data,
    input  logic [DATA_WIDTH/8-1:0] bus_byte_enable,
    input  logic                    bus_read_enable,
    input  logic                    bus_write_enable,
    output logic [DATA_WIDTH-1:0]   bus_read_data,
    output logic                    bus_read_valid,
    output logic                    bus_wait,
    output logic                    bus_error
`ifdef BUS_MEM_STATS_EN
    ,
    output logic [31:0]             stat_reads,
    output logic [31:0]             stat_writes,
    output logic [31:0]             stat_errors
`endif
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFS   = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int HI    = OFS + IDX_W;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    pend_rd_q, pend_rd_d;
    logic                    pend_wr_q, pend_wr_d;
    logic [ADDR_WIDTH-1:0]   pend_addr_q, pend_addr_d;
    logic [DATA_WIDTH-1:0]   pend_wdata_q, pend_wdata_d;
    logic [BYTES-1:0]        pend_be_q, pend_be_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    rvalid_q, rvalid_d;
    logic                    wait_q, wait_d;
    logic                    err_q, err_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH_WORDS];

    logic                    accept;
    logic                    c_fire;
    logic                    c_rd;
    logic                    c_wr;
    logic [ADDR_WIDTH-1:0]   c_addr;
    logic [DATA_WIDTH-1:0]   c_wdata;
    logic [BYTES-1:0]        c_be;
    logic [IDX_W-1:0]        c_idx;
    logic                    c_oor;
    logic                    mem_we;
    logic                    rd_done;
    logic                    err_done;

    // Pick which access completes this edge: the live request when there are
    // no wait states, otherwise the latched one once the countdown hits 1.
    always_comb begin
        accept = (state_q == IDLE) && !wait_q && (bus_read_enable || bus_write_enable);
        if (WAIT_STATES == 0) begin
            c_fire  = accept;
            c_rd    = bus_read_enable;
            c_wr    = bus_write_enable;
            c_addr  = bus_address;
            c_wdata = bus_write_data;
            c_be    = bus_byte_enable;
        end else begin
            c_fire  = (state_q == BUSY) && (cnt_q == 4'd1);
            c_rd    = pend_rd_q;
            c_wr    = pend_wr_q;
            c_addr  = pend_addr_q;
            c_wdata = pend_wdata_q;
            c_be    = pend_be_q;
        end
        c_idx    = c_addr[OFS +: IDX_W];
        c_oor    = (c_addr >> HI) != '0;
        mem_we   = c_fire && c_wr && !c_oor;
        rd_done  = c_fire && c_rd && !c_wr;
        err_done = c_fire && (c_oor || (c_rd && c_wr));
    end

    // Next-state logic for the IDLE/BUSY handshake and the registered outputs.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pend_rd_d    = pend_rd_q;
        pend_wr_d    = pend_wr_q;
        pend_addr_d  = pend_addr_q;
        pend_wdata_d = pend_wdata_q;
        pend_be_d    = pend_be_q;
        wait_d       = wait_q;
        rdata_d      = rdata_q;
        rvalid_d     = rd_done;
        err_d        = err_done;
        if (rd_done) begin
            rdata_d = c_oor ? '0 : mem[c_idx];
        end
        case (state_q)
            IDLE: begin
                if (accept && (WAIT_STATES != 0)) begin
                    state_d      = BUSY;
                    cnt_d        = WAIT_LOAD;
                    wait_d       = 1'b1;
                    pend_rd_d    = bus_read_enable;
                    pend_wr_d    = bus_write_enable;
                    pend_addr_d  = bus_address;
                    pend_wdata_d = bus_write_data;
                    pend_be_d    = bus_byte_enable;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd1) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                    wait_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                wait_d  = 1'b0;
            end
        endcase
    end

    // Storage write port; a reset edge aborts any write completing on it.
    always_ff @(posedge clock) begin
        if (!reset && mem_we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (c_be[b]) begin
                    mem[c_idx][8*b +: 8] <= c_wdata[8*b +: 8];
                end
            end
        end
    end

    // Control and output registers; memory contents survive reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            pend_rd_q    <= 1'b0;
            pend_wr_q    <= 1'b0;
            pend_addr_q  <= '0;
            pend_wdata_q <= '0;
            pend_be_q    <= '0;
            wait_q       <= 1'b0;
            rdata_q      <= '0;
            rvalid_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pend_rd_q    <= pend_rd_d;
            pend_wr_q    <= pend_wr_d;
            pend_addr_q  <= pend_addr_d;
            pend_wdata_q <= pend_wdata_d;
            pend_be_q    <= pend_be_d;
            wait_q       <= wait_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
            err_q        <= err_d;
        end
    end

    assign bus_read_data  = rdata_q;
    assign bus_read_valid = rvalid_q;
    assign bus_wait       = wait_q;
    assign bus_error      = err_q;

`ifdef BUS_MEM_STATS_EN
    logic [31:0] reads_q, reads_d;
    logic [31:0] writes_q, writes_d;
    logic [31:0] errors_q, errors_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

    // Saturating counters; a conflicting access counts as a write and an error.
    always_comb begin
        reads_d  = sat_inc(reads_q, rd_done);
        writes_d = sat_inc(writes_q, c_fire && c_wr);
        errors_d = sat_inc(errors_q, err_done);
    end

    // Counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            reads_q  <= '0;
            writes_q <= '0;
            errors_q <= '0;
        end else begin
            reads_q  <= reads_d;
            writes_q <= writes_d;
            errors_q <= errors_d;
        end
    end

    assign stat_reads  = reads_q;
    assign stat_writes = writes_q;
    assign stat_errors = errors_q;
`endif

endmodule

// File: tb/tb_bus_mem_slave.sv
// tb_bus_mem_slave: three slaves (0, 3 and 4 wait states) on a shared clock and
// reset, driven by directed scenarios and random traffic; a word-array model
// with byte-lane merging predicts every completion.

module tb_bus_mem_slave;

    logic        clock;
    logic        reset;
    logic [31:0] addr   [3];
    logic [31:0] wdata  [3];
    logic [3:0]  be     [3];
    logic        rd     [3];
    logic        wr     [3];
    logic [31:0] rdata  [3];
    logic        rvalid [3];
    logic        bwait  [3];
    logic        berr   [3];
`ifdef BUS_MEM_STATS_EN
    logic [31:0] st_r [3];
    logic [31:0] st_w [3];
    logic [31:0] st_e [3];
`endif

    int          n_checks = 0;
    int          n_fail   = 0;

    logic [31:0] ref_mem    [3][1024];
    logic [31:0] last_rdata [3];
    int          m_reads    [3];
    int          m_writes   [3];
    int          m_errors   [3];

    bus_mem_slave #(.WAIT_STATES(0)) dut0 (
        .clock(clock), .reset(reset), .bus_address(addr[0]), .bus_write_data(wdata[0]),
        .bus_byte_enable(be[0]), .bus_read_enable(rd[0]), .bus_write_enable(wr[0]),
        .bus_read_data(rdata[0]), .bus_read_valid(rvalid[0]), .bus_wait(bwait[0]),
        .bus_error(berr[0])
`ifdef BUS_MEM_STATS_EN
        , .stat_reads(st_r[0]), .stat_writes(st_w[0]), .stat_errors(st_e[0])
`endif
    );

    bus_mem_slave #(.WAIT_STATES(3)) dut1 (
        .clock(clock), .reset(reset), .bus_address(addr[1]), .bus_write_data(wdata[1]),
        .bus_byte_enable(be[1]), .bus_read_enable(rd[1]), .bus_write_enable(wr[1]),
        .bus_read_data(rdata[1]), .bus_read_valid(rvalid[1]), .bus_wait(bwait[1]),
        .bus_error(berr[1])
`ifdef BUS_MEM_STATS_EN
        , .stat_reads(st_r[1]), .stat_writes(st_w[1]), .stat_errors(st_e[1])
`endif
    );

    bus_mem_slave #(.WAIT_STATES(4)) dut2 (
        .clock(clock), .reset(reset), .bus_address(addr[2]), .bus_write_data(wdata[2]),
        .bus_byte_enable(be[2]), .bus_read_enable(rd[2]), .bus_write_enable(wr[2]),
        .bus_read_data(rdata[2]), .bus_read_valid(rvalid[2]), .bus_wait(bwait[2]),
        .bus_error(berr[2])
`ifdef BUS_MEM_STATS_EN
        , .stat_reads(st_r[2]), .stat_writes(st_w[2]), .stat_errors(st_e[2])
`endif
    );

    // Free-running 10-unit clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic int ws_of(input int i);
        case (i)
            0:       return 0;
            1:       return 3;
            default: return 4;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model_after_reset();
        for (int i = 0; i < 3; i++) begin
            last_rdata[i] = 32'h0;
            m_reads[i]    = 0;
            m_writes[i]   = 0;
            m_errors[i]   = 0;
        end
    endtask

    // One bus access on slave i, checked through completion; with tail set the
    // following cycle is checked for the strobes dropping.
    task automatic applyStimulus(input int i, input bit r, input bit w, input logic [31:0] a,
                                 input logic [31:0] d, input logic [3:0] b, input bit tail);
        int          ws;
        bit          oor;
        int          idx;
        bit          exp_v;
        bit          exp_e;
        ws    = ws_of(i);
        oor   = (a[31:12] != 20'h0);
        idx   = int'(a[11:2]);
        exp_v = r && !w;
        exp_e = oor || (r && w);
        @(negedge clock);
        rd[i] = r; wr[i] = w; addr[i] = a; wdata[i] = d; be[i] = b;
        @(posedge clock);
        #1;
        rd[i] = 1'b0; wr[i] = 1'b0;
        for (int k = 0; k < ws; k++) begin
            checkOutput("busy_wait", bwait[i], 1'b1);
            checkOutput("busy_no_valid", rvalid[i], 1'b0);
            @(posedge clock);
            #1;
        end
        checkOutput("done_wait", bwait[i], 1'b0);
        checkOutput("done_valid", rvalid[i], exp_v);
        checkOutput("done_error", berr[i], exp_e);
        if (exp_v) last_rdata[i] = oor ? 32'h0 : ref_mem[i][idx];
        checkOutput("read_data", rdata[i], last_rdata[i]);
        if (w && !oor) begin
            for (int k = 0; k < 4; k++) begin
                if (b[k]) ref_mem[i][idx][8*k +: 8] = d[8*k +: 8];
            end
        end
        if (exp_v) m_reads[i]++;
        if (w) m_writes[i]++;
        if (exp_e) m_errors[i]++;
        if (tail) begin
            @(posedge clock);
            #1;
            checkOutput("strobe_valid_off", rvalid[i], 1'b0);
            checkOutput("strobe_error_off", berr[i], 1'b0);
            checkOutput("idle_wait", bwait[i], 1'b0);
        end
    endtask

    // Directed scenarios followed by random traffic on all three slaves.
    initial begin
        int          kind;
        bit          r;
        bit          w;
        int          sel;
        logic [31:0] a;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            addr[i] = 32'h0; wdata[i] = 32'h0; be[i] = 4'h0; rd[i] = 1'b0; wr[i] = 1'b0;
        end
        clear_model_after_reset();
        repeat (2) @(posedge clock);
        #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput("reset_rdata", rdata[i], 32'h0);
            checkOutput("reset_valid", rvalid[i], 1'b0);
            checkOutput("reset_wait", bwait[i], 1'b0);
            checkOutput("reset_error", berr[i], 1'b0);
        end
        @(negedge clock);
        reset = 1'b0;

        $display("[TB] zero-wait write/read, byte lanes, out of range");
        applyStimulus(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
        applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1);
        checkOutput("b2b_read", rdata[0], 32'hDEADBEEF);
        applyStimulus(0, 1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, 1'b1);
        applyStimulus(0, 1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b1);
        applyStimulus(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1);
        checkOutput("lane_merge", rdata[0], 32'h11BB33DD);
        applyStimulus(0, 1'b0, 1'b1, 32'h0, 32'h0BADF00D, 4'hF, 1'b1);
        applyStimulus(0, 1'b0, 1'b1, 32'h1000, 32'h12345678, 4'hF, 1'b1);
        applyStimulus(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
        checkOutput("oor_no_alias", rdata[0], 32'h0BADF00D);
        applyStimulus(0, 1'b1, 1'b0, 32'h1000, 32'h0, 4'h0, 1'b1);

        $display("[TB] three-wait read with ignored request");
        applyStimulus(1, 1'b0, 1'b1, 32'h10, 32'hCAFE0001, 4'hF, 1'b1);
        applyStimulus(1, 1'b0, 1'b1, 32'h40, 32'hA5A5A5A5, 4'hF, 1'b1);
        @(negedge clock);
        rd[1] = 1'b1; addr[1] = 32'h10;
        @(posedge clock);
        #1;
        rd[1] = 1'b0;
        checkOutput("w3_wait_n1", bwait[1], 1'b1);
        @(negedge clock);
        wr[1] = 1'b1; addr[1] = 32'h40; wdata[1] = 32'h5A5A5A5A; be[1] = 4'hF;
        @(posedge clock);
        #1;
        wr[1] = 1'b0;
        checkOutput("w3_wait_n2", bwait[1], 1'b1);
        checkOutput("w3_valid_n2", rvalid[1], 1'b0);
        @(posedge clock);
        #1;
        checkOutput("w3_wait_n3", bwait[1], 1'b1);
        @(posedge clock);
        #1;
        checkOutput("w3_done_wait", bwait[1], 1'b0);
        checkOutput("w3_done_valid", rvalid[1], 1'b1);
        checkOutput("w3_done_data", rdata[1], 32'hCAFE0001);
        last_rdata[1] = 32'hCAFE0001;
        m_reads[1]++;
        @(posedge clock);
        #1;
        checkOutput("w3_valid_off", rvalid[1], 1'b0);
        checkOutput("w3_no_second", bwait[1], 1'b0);
        applyStimulus(1, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b1);
        checkOutput("ignored_write", rdata[1], 32'hA5A5A5A5);

        $display("[TB] reset during a pending write");
        applyStimulus(2, 1'b0, 1'b1, 32'h8, 32'h000000AA, 4'hF, 1'b1);
        @(negedge clock);
        wr[2] = 1'b1; addr[2] = 32'h8; wdata[2] = 32'h55; be[2] = 4'hF;
        @(posedge clock);
        #1;
        wr[2] = 1'b0;
        @(posedge clock);
        #1;
        checkOutput("abort_wait_before", bwait[2], 1'b1);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        clear_model_after_reset();
        checkOutput("abort_wait_cleared", bwait[2], 1'b0);
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clock);
            #1;
            checkOutput("abort_no_valid", rvalid[2], 1'b0);
            checkOutput("abort_no_error", berr[2], 1'b0);
            checkOutput("abort_no_wait", bwait[2], 1'b0);
        end
        applyStimulus(2, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0, 1'b1);
        checkOutput("abort_old_data", rdata[2], 32'h000000AA);

`ifdef BUS_MEM_STATS_EN
        $display("[TB] statistics counters");
        clear_model_after_reset();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
        for (int k = 0; k < 2; k++) applyStimulus(0, 1'b0, 1'b1, 32'h30, 32'h100 + k, 4'hF, 1'b0);
        applyStimulus(0, 1'b1, 1'b1, 32'h30, 32'h777, 4'hF, 1'b1);
        checkOutput("stat_reads_3", st_r[0], 32'd3);
        checkOutput("stat_writes_3", st_w[0], 32'd3);
        checkOutput("stat_errors_1", st_e[0], 32'd1);
`endif

        $display("[TB] random traffic");
        for (int i = 0; i < 3; i++) begin
            for (int wd = 0; wd < 16; wd++) begin
                applyStimulus(i, 1'b0, 1'b1, 32'(wd) << 2, $urandom, 4'hF, 1'b0);
            end
            for (int n = 0; n < 25; n++) begin
                kind = $urandom_range(0, 9);
                a    = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
                if (kind <= 3) begin
                    r = 1'b1; w = 1'b0;
                end else if (kind <= 7) begin
                    r = 1'b0; w = 1'b1;
                end else if (kind == 8) begin
                    r = 1'b1; w = 1'b1;
                end else begin
                    sel = $urandom_range(1, 3);
                    r = sel[0]; w = sel[1];
                    a = a | (32'h1000 << $urandom_range(0, 19));
                end
                applyStimulus(i, r, w, a, $urandom, 4'($urandom_range(0, 15)), n[0]);
            end
        end

`ifdef BUS_MEM_STATS_EN
        for (int i = 0; i < 3; i++) begin
            checkOutput("stat_reads", st_r[i], 32'(m_reads[i]));
            checkOutput("stat_writes", st_w[i], 32'(m_writes[i]));
            checkOutput("stat_errors", st_e[i], 32'(m_errors[i]));
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_mem_slave.md
Name: bus_mem_slave

Overview:
- Parametrised synchronous memory slave on the toplevel instruction/data bus: read_enable/write_enable, address, write data, byte enables, read data.
- Adds configurable wait states with a `bus_wait` stall output, a read-valid strobe, and out-of-range error reporting.
- Instantiated in the top-level test harness next to the core; also usable as on-chip RAM.

Parameters:
- DATA_WIDTH, 32, bus data width in bits; power of two, >= 8.
- ADDR_WIDTH, 32, byte-address width.
- DEPTH_WORDS, 1024, memory depth in DATA_WIDTH words; power of two.
- WAIT_STATES, 0, stall cycles per access; range 0..15.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- bus_address  in  ADDR_WIDTH  byte address.
- bus_write_data  in  DATA_WIDTH  write data.
- bus_byte_enable  in  DATA_WIDTH/8  per-byte write lane enables.
- bus_read_enable  in  1  read request.
- bus_write_enable  in  1  write request.
- bus_read_data  out  DATA_WIDTH  registered read data.
- bus_read_valid  out  1  one-cycle strobe: bus_read_data updated.
- bus_wait  out  1  slave busy; new requests ignored while high.
- bus_error  out  1  one-cycle strobe: out-of-range or conflicting access.

Behaviour:
- Interface: one clock, `clock`. Reset `reset` is synchronous and active-high.
- Reset values: bus_read_data=0, bus_read_valid=0, bus_wait=0, bus_error=0, state IDLE, wait counter 0. Memory contents are not cleared by reset.
- Addressing: word index = bus_address[OFS +: log2(DEPTH_WORDS)], where OFS = log2(DATA_WIDTH/8). Low OFS bits are ignored; no misalignment error.
- Out of range: any nonzero address bit above the index field. Write is discarded, read returns 0, bus_error pulses with the completion.
- Acceptance: a request is sampled at a rising edge only when state=IDLE and bus_wait=0. Requests at any other time are dropped, not queued.
- Simultaneous read_enable and write_enable: the write is performed, the read is dropped, bus_error pulses.
- States:
  - IDLE: on a request with WAIT_STATES=0, complete at the same edge and stay in IDLE. With WAIT_STATES>0, latch address/data/be/type, load counter=WAIT_STATES, go to BUSY, bus_wait=1.
  - BUSY: counter decrements each cycle. At the edge where counter reaches 1, complete the access, set bus_wait=0, return to IDLE.
- Completion:
  - Write commits only lanes with byte_enable=1.
  - Read loads the full word into bus_read_data; bus_read_valid=1 for exactly the following cycle.
- Latency: a request sampled at edge N completes at edge N+WAIT_STATES. Read data is visible after that edge. Throughput is one access per WAIT_STATES+1 cycles.
- bus_read_data holds its value until the next completed read.
- Read-after-write to the same address in back-to-back accesses returns the new data.
- Reset in BUSY: pending access is aborted (no write, no read_valid, no error). Next cycle: bus_wait=0, state IDLE.

Optional Feature:
- Macro BUS_MEM_STATS_EN.
- Defined: adds outputs stat_reads, stat_writes, stat_errors (each 32 bits, reset 0). Each increments by 1 on the corresponding completion and saturates at 32'hFFFF_FFFF. A conflicting read+write increments stat_writes and stat_errors.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- WAIT_STATES=0: write 0xDEADBEEF to 0x10 with be=4'hF, then read 0x10 next cycle -> bus_read_data=0xDEADBEEF, read_valid high 1 cycle after the read edge, bus_wait never high.
- Byte lanes: word 0x20 holds 0x11223344; write 0xAABBCCDD with be=4'b0101 -> read returns 0x11BB33DD.
- WAIT_STATES=3: read at edge N -> bus_wait high cycles N+1..N+3, data valid after edge N+3. A second request issued during the wait is ignored (memory and read count unchanged).
- Out of range, DEPTH_WORDS=1024: write to 0x0000_1000 -> bus_error pulse, memory unchanged. Read to 0x0000_1000 -> data 0, read_valid and bus_error both pulse.
- Reset mid-access, WAIT_STATES=4: write 0x55 to 0x8, assert reset 2 cycles later -> bus_wait=0 next cycle, read of 0x8 returns the old value, no read_valid or error from the aborted access.
- BUS_MEM_STATS_EN: 3 reads, 2 writes, 1 simultaneous read+write -> stat_reads=3, stat_writes=3, stat_errors=1.
